// File: rtl/cr_ifu_lpmd_drain.sv
// ---------------------------------------------------------------------------
// cr_ifu_lpmd_drain
//
// IFU-side responder to the CP0 low-power-mode request. When CP0 raises
// cp0_ifu_lpmd_req, new fetch requests are masked, the in-flight fetches are
// counted down as they complete, and ifu_cp0_lpmd_ack is raised once the IFU
// has no outstanding bus traffic. The ack is held while the request stays
// high, because the cache half of the CP0 ack AND may arrive later.
//
// Parameters:
//   OUTSTD_MAX - max in-flight fetch transactions tracked (1..3)
//   CNT_W      - width of the outstanding counter (must hold OUTSTD_MAX)
//
// Ports:
//   lpmd_sm_clk         in   gated state-machine clock
//   cpurst_b            in   asynchronous active-low reset
//   cp0_ifu_lpmd_req    in   low-power request from CP0 (level)
//   cp0_ifu_in_lpmd     in   CPU currently in low-power mode
//   iu_yy_xx_flush      in   pipeline flush, returns the FSM to IDLE
//   ifu_bus_req         in   IFU fetch request to bus (before masking)
//   bus_ifu_grnt        in   bus accepted a fetch request
//   bus_ifu_cmplt       in   fetch data phase complete (one per grant)
//   ifu_bus_req_mask    out  suppress new fetch requests
//   ifu_cp0_lpmd_ack    out  IFU drained, safe to enter low power
//   ifu_lpmd_clk_en     out  keep lpmd_sm_clk running
//   ifu_lpmd_outstd_cnt out  current in-flight count (debug)
//   ifu_lpmd_err        out  sticky counter underflow/overflow flag
//                            (present only with IFU_LPMD_ERR_CHK_EN)
//
// Build option: define IFU_LPMD_ERR_CHK_EN to add the ifu_lpmd_err checker.
// ---------------------------------------------------------------------------
module cr_ifu_lpmd_drain #(
    parameter int OUTSTD_MAX = 2,
    parameter int CNT_W      = 2
) (
    input  logic             lpmd_sm_clk,
    input  logic             cpurst_b,
    input  logic             cp0_ifu_lpmd_req,
    input  logic             cp0_ifu_in_lpmd,
    input  logic             iu_yy_xx_flush,
    input  logic             ifu_bus_req,
    input  logic             bus_ifu_grnt,
    input  logic             bus_ifu_cmplt,
    output logic             ifu_bus_req_mask,
    output logic             ifu_cp0_lpmd_ack,
    output logic             ifu_lpmd_clk_en,
    output logic [CNT_W-1:0] ifu_lpmd_outstd_cnt
`ifdef IFU_LPMD_ERR_CHK_EN
    ,
    output logic             ifu_lpmd_err
`endif
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] DRAIN = 2'b01;
    localparam logic [1:0] ACK   = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_grant;
    logic             w_cnt_full;
    logic             w_cnt_zero;

    assign w_cnt_full = (r_cnt == CNT_MAX);
    assign w_cnt_zero = (r_cnt == '0);

    // Mask depends only on flops plus cp0_ifu_in_lpmd, so a grant in the
    // same cycle the request first rises (state still IDLE) is still counted.
    assign ifu_bus_req_mask = (r_state != IDLE) || cp0_ifu_in_lpmd || w_cnt_full;
    assign w_grant          = ifu_bus_req && bus_ifu_grnt && !ifu_bus_req_mask;

    // Outstanding counter next value. Grant and cmplt together cancel out;
    // cmplt at zero is dropped and grant at full saturates.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_grant && !bus_ifu_cmplt) begin
            if (!w_cnt_full) w_cnt_nxt = r_cnt + CNT_ONE;
        end else if (bus_ifu_cmplt && !w_grant) begin
            if (!w_cnt_zero) w_cnt_nxt = r_cnt - CNT_ONE;
        end
    end

    // Flush wins over every transition but leaves the counter alone, since
    // the bus still completes whatever was granted.
    always_comb begin
        w_state_nxt = r_state;
        if (iu_yy_xx_flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (cp0_ifu_lpmd_req)  w_state_nxt = DRAIN;
                DRAIN:   if (w_cnt_nxt == '0)   w_state_nxt = ACK;
                ACK:     if (!cp0_ifu_lpmd_req) w_state_nxt = IDLE;
                default:                        w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge lpmd_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign ifu_cp0_lpmd_ack    = (r_state == ACK);
    assign ifu_lpmd_outstd_cnt = r_cnt;

    // Clock must run whenever the counter or FSM could change next edge.
    assign ifu_lpmd_clk_en = cp0_ifu_lpmd_req || ifu_bus_req || !w_cnt_zero ||
                             (r_state != IDLE);

`ifdef IFU_LPMD_ERR_CHK_EN
    logic r_err;
    logic w_udf;
    logic w_ovf;

    assign w_udf = bus_ifu_cmplt && !w_grant && w_cnt_zero;
    // A grant while full means the bus accepted a request the mask was
    // covering; the counter has lost track of one transaction.
    assign w_ovf = ifu_bus_req && bus_ifu_grnt && w_cnt_full;

    always_ff @(posedge lpmd_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) r_err <= 1'b0;
        else if (w_udf || w_ovf) r_err <= 1'b1;
    end

    assign ifu_lpmd_err = r_err;
`endif

endmodule

// File: tb/tb_cr_ifu_lpmd_drain.sv
module tb_cr_ifu_lpmd_drain;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       req, inl, fl, breq, gr, cm;
    logic       mask, ack, clken;
    logic [1:0] cnt;
`ifdef IFU_LPMD_ERR_CHK_EN
    logic       err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cr_ifu_lpmd_drain #(.OUTSTD_MAX(2), .CNT_W(2)) dut (
        .lpmd_sm_clk        (clk),
        .cpurst_b           (rst_b),
        .cp0_ifu_lpmd_req   (req),
        .cp0_ifu_in_lpmd    (inl),
        .iu_yy_xx_flush     (fl),
        .ifu_bus_req        (breq),
        .bus_ifu_grnt       (gr),
        .bus_ifu_cmplt      (cm),
        .ifu_bus_req_mask   (mask),
        .ifu_cp0_lpmd_ack   (ack),
        .ifu_lpmd_clk_en    (clken),
        .ifu_lpmd_outstd_cnt(cnt)
`ifdef IFU_LPMD_ERR_CHK_EN
        ,
        .ifu_lpmd_err       (err)
`endif
    );

    // One vector = inputs for one cycle, combinational outputs expected
    // before the edge, registered outputs expected after it.
    typedef struct {
        logic       req, inl, fl, breq, gr, cm;
        logic       e_mask, e_clk;
        logic [1:0] e_cnt;
        logic       e_ack;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] cnt;
        logic       ack;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input int r, i, f, b, g, c, m, k, n, a);
        vec_t v;
        v.req = r[0]; v.inl = i[0]; v.fl = f[0]; v.breq = b[0]; v.gr = g[0];
        v.cm = c[0]; v.e_mask = m[0]; v.e_clk = k[0]; v.e_cnt = n[1:0];
        v.e_ack = a[0];
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        req = 0; inl = 0; fl = 0; breq = 0; gr = 0; cm = 0;
    endtask

    task automatic step(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        req = v.req; inl = v.inl; fl = v.fl; breq = v.breq; gr = v.gr; cm = v.cm;
        #1;
        chk("mask", idx, {31'd0, mask}, {31'd0, v.e_mask});
        chk("clk_en", idx, {31'd0, clken}, {31'd0, v.e_clk});
        e.idx = idx; e.cnt = v.e_cnt; e.ack = v.e_ack;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty vec=%0d", idx);
        end else begin
            e = sbq.pop_front();
            chk("cnt", e.idx, {30'd0, cnt}, {30'd0, e.cnt});
            chk("ack", e.idx, {31'd0, ack}, {31'd0, e.ack});
        end
    endtask

    initial begin
        //  req inl fl breq gr cm | mask clk | cnt ack
        // idle entry
        add(1,0,0,0,0,0, 0,1, 0,0);
        add(1,0,0,0,0,0, 1,1, 0,1);
        add(1,0,0,0,0,0, 1,1, 0,1);
        add(0,0,0,0,0,0, 1,1, 0,0);
        add(0,1,0,0,0,0, 1,0, 0,0);
        add(0,0,0,0,0,0, 0,0, 0,0);
        // drain with two outstanding, masked grants ignored
        add(0,0,0,1,1,0, 0,1, 1,0);
        add(0,0,0,1,1,0, 0,1, 2,0);
        add(1,0,0,1,1,0, 1,1, 2,0);
        add(1,0,0,0,0,1, 1,1, 1,0);
        add(1,0,0,1,1,0, 1,1, 1,0);
        add(1,0,0,0,0,1, 1,1, 0,1);
        add(0,0,0,0,0,0, 1,1, 0,0);
        // grant in the same cycle req rises
        add(1,0,0,1,1,0, 0,1, 1,0);
        add(1,0,0,0,0,0, 1,1, 1,0);
        add(1,0,0,0,0,1, 1,1, 0,1);
        add(0,0,0,0,0,0, 1,1, 0,0);
        // grant+cmplt together, full counter masks while IDLE, underflow
        add(0,0,0,1,1,0, 0,1, 1,0);
        add(0,0,0,1,1,1, 0,1, 1,0);
        add(0,0,0,1,1,0, 0,1, 2,0);
        add(0,0,0,0,0,0, 1,1, 2,0);
        add(0,0,0,0,0,1, 1,1, 1,0);
        add(0,0,0,0,0,1, 0,1, 0,0);
        add(0,0,0,0,0,1, 0,0, 0,0);
        // flush in DRAIN keeps the counter
        add(0,0,0,1,1,0, 0,1, 1,0);
        add(1,0,0,0,0,0, 0,1, 1,0);
        add(1,0,1,0,0,0, 1,1, 1,0);
        add(0,0,0,0,0,0, 0,1, 1,0);
        add(0,0,0,0,0,1, 0,1, 0,0);
        // req dropped during DRAIN: one-cycle ack pulse
        add(1,0,0,1,1,0, 0,1, 1,0);
        add(0,0,0,0,0,0, 1,1, 1,0);
        add(0,0,0,0,0,1, 1,1, 0,1);
        add(0,0,0,0,0,0, 1,1, 0,0);
        add(0,0,0,0,0,0, 0,0, 0,0);
        // flush in ACK
        add(1,0,0,0,0,0, 0,1, 0,0);
        add(1,0,0,0,0,0, 1,1, 0,1);
        add(1,0,1,0,0,0, 1,1, 0,0);
        add(0,0,0,0,0,0, 0,0, 0,0);

        // reset state
        drive_idle();
        rst_b = 1'b0;
        #1;
        chk("rst_cnt", -1, {30'd0, cnt}, 32'd0);
        chk("rst_ack", -1, {31'd0, ack}, 32'd0);
        chk("rst_mask", -1, {31'd0, mask}, 32'd0);
        chk("rst_clk_en", -1, {31'd0, clken}, 32'd0);
`ifdef IFU_LPMD_ERR_CHK_EN
        chk("rst_err", -1, {31'd0, err}, 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // async reset while in ACK: outputs drop without a clock edge
        begin
            vec_t v;
            v = tbl[0]; step(100, v);
            v = tbl[1]; step(101, v);
            #2;
            rst_b = 1'b0;
            #1;
            chk("async_ack", 102, {31'd0, ack}, 32'd0);
            chk("async_mask", 102, {31'd0, mask}, 32'd0);
            chk("async_cnt", 102, {30'd0, cnt}, 32'd0);
            @(negedge clk);
            drive_idle();
            rst_b = 1'b1;
        end

        // async reset with counter full: counter clears immediately
        begin
            vec_t v;
            v = tbl[6]; step(103, v);
            v = tbl[7]; step(104, v);
            @(negedge clk);
            drive_idle();
            #2;
            rst_b = 1'b0;
            #1;
            chk("async_cnt_full", 105, {30'd0, cnt}, 32'd0);
            chk("async_mask_full", 105, {31'd0, mask}, 32'd0);
            @(negedge clk);
            rst_b = 1'b1;
        end

`ifdef IFU_LPMD_ERR_CHK_EN
        // underflow sets the sticky error, only reset clears it
        @(negedge clk);
        cm = 1'b1;
        @(posedge clk);
        #1;
        chk("err_set", 106, {31'd0, err}, 32'd1);
        @(negedge clk);
        cm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("err_sticky", 107, {31'd0, err}, 32'd1);
        rst_b = 1'b0;
        #1;
        chk("err_rst", 108, {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
`endif

        if (sbq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_left actual=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
